// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - state encoding and default constants for the SPI arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_TIMEOUT       = 65535;

  // Index width covers the largest supported requester count (8).
  localparam int IDX_W = 3;

endpackage

// File: rtl/spi_arbiter_rr_arbiter.sv
// rtl/spi_arbiter_rr_arbiter.sv - combinational round-robin requester selection
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic found;

  // Scan from the requester after the last winner, wrapping once around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_idx) + 1 + off) % NUM_REQ))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master; SPI_ARB_TIMEOUT_EN adds a watchdog
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int          NUM_REQ       = DEF_NUM_REQ,
  parameter int          DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int          ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_rd_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             err,
  output logic                             spi_enable,
  output logic                             spi_rd_we,
  output logic [ADDRESS_WIDTH-1:0]         spi_address,
  output logic [DATA_WIDTH-1:0]            spi_data,
  input  logic                             spi_busy,
  input  logic [DATA_WIDTH-1:0]            spi_data_read,
  input  logic                             spi_data_read_valid
);

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           last_idx, cur_idx;
  logic [NUM_REQ-1:0]         rr_grant;
  logic [IDX_W-1:0]           rr_idx;
  logic                       rr_valid;
  logic                       grant_fire;
  logic                       timeout_hit;
  logic                       sel_rd_we;
  logic [ADDRESS_WIDTH-1:0]   sel_address;
  logic [DATA_WIDTH-1:0]      sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req      (req),
    .last_idx (last_idx),
    .grant    (rr_grant),
    .idx      (rr_idx),
    .valid    (rr_valid)
  );

  // Grant is a same-cycle pulse in IDLE; reset_n keeps it quiet while reset is held.
  assign grant_fire = reset_n && (state == IDLE) && rr_valid && !spi_busy;
  assign gnt        = grant_fire ? rr_grant : '0;

  // Pick the winning requester's payload for latching.
  always_comb begin
    sel_rd_we   = 1'b0;
    sel_address = '0;
    sel_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_grant[i]) begin
        sel_rd_we   = req_rd_we[i];
        sel_address = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] timer;
  logic        err_q;

  assign timeout_hit = ((state == ISSUE) || (state == WAIT_DONE)) &&
                       (timer == 16'(TIMEOUT - 1));
  assign err = err_q;

  // Watchdog counts cycles spent in ISSUE/WAIT_DONE; err lines up with the RESP cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_fire)
        timer <= '0;
      else if ((state == ISSUE) || (state == WAIT_DONE))
        timer <= timer + 16'd1;
      err_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register plus latched transaction context.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_idx    <= IDX_W'(NUM_REQ - 1);
      cur_idx     <= '0;
      spi_rd_we   <= 1'b0;
      spi_address <= '0;
      spi_data    <= '0;
      rdata       <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        last_idx    <= rr_idx;
        cur_idx     <= rr_idx;
        spi_rd_we   <= sel_rd_we;
        spi_address <= sel_address;
        spi_data    <= sel_data;
        rdata       <= '0;
      end else if (timeout_hit) begin
        rdata <= '0;
      end else if ((state == WAIT_DONE) && spi_data_read_valid && spi_rd_we) begin
        rdata <= spi_data_read;
      end
    end
  end

  // Next-state and master/done outputs.
  always_comb begin
    state_nxt  = state;
    spi_enable = 1'b0;
    done       = '0;
    case (state)
      IDLE: begin
        if (grant_fire) state_nxt = ISSUE;
      end
      ISSUE: begin
        spi_enable = !spi_busy && !timeout_hit;
        if (timeout_hit)   state_nxt = RESP;
        else if (spi_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout_hit || !spi_busy) state_nxt = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++)
          if (cur_idx == IDX_W'(i)) done[i] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 100;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_rd_we;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            spi_enable;
  logic            spi_rd_we;
  logic [AW-1:0]   spi_address;
  logic [DW-1:0]   spi_data;
  logic            spi_busy;
  logic [DW-1:0]   spi_data_read;
  logic            spi_data_read_valid;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req(req), .req_rd_we(req_rd_we), .req_address(req_address), .req_data(req_data),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .spi_enable(spi_enable), .spi_rd_we(spi_rd_we), .spi_address(spi_address),
    .spi_data(spi_data), .spi_busy(spi_busy), .spi_data_read(spi_data_read),
    .spi_data_read_valid(spi_data_read_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n             = 1'b0;
    req                 = '0;
    req_rd_we           = '0;
    req_address         = '0;
    req_data            = '0;
    spi_busy            = 1'b0;
    spi_data_read       = '0;
    spi_data_read_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  // Plays the SPI master: called at a negedge in ISSUE, returns at the negedge in RESP.
  task automatic spi_serve(input int busy_len, input logic give_data, input logic [DW-1:0] val);
    spi_busy = 1'b1;
    repeat (busy_len) @(negedge clock);
    if (give_data) begin
      spi_data_read       = val;
      spi_data_read_valid = 1'b1;
    end
    @(negedge clock);
    spi_data_read_valid = 1'b0;
    spi_busy            = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    do_reset();
    checks++; if ({done, err, spi_enable, spi_rd_we} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got done=%b err=%b en=%b rdwe=%b want 0", done, err, spi_enable, spi_rd_we); end
    checks++; if ({rdata, spi_address, spi_data} !== 96'h0) begin errors++; $display("FAIL reset_data: got rdata=%h addr=%h data=%h want 0", rdata, spi_address, spi_data); end
  endtask

  task automatic test_single_write();
    do_reset();
    req_address[0*AW +: AW] = 32'h0000_00A5;
    req_data[0*DW +: DW]    = 32'h0000_1234;
    req_rd_we[0]            = 1'b0;
    req                     = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
    @(negedge clock);
    req = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_pulse: got %b want 0000", gnt); end
    checks++; if (spi_enable !== 1'b1) begin errors++; $display("FAIL wr_enable: got %b want 1", spi_enable); end
    checks++; if ({spi_rd_we, spi_address, spi_data} !== {1'b0, 32'hA5, 32'h1234}) begin errors++; $display("FAIL wr_payload: got %b %h %h want 0 a5 1234", spi_rd_we, spi_address, spi_data); end
    spi_busy = 1'b1;
    #1;
    checks++; if (spi_enable !== 1'b0) begin errors++; $display("FAIL wr_enable_drop: got %b want 0", spi_enable); end
    @(negedge clock);
    #1;
    checks++; if ({spi_address, spi_data, done} !== {32'hA5, 32'h1234, 4'b0000}) begin errors++; $display("FAIL wr_wait_hold: got %h %h done=%b", spi_address, spi_data, done); end
    spi_serve(1, 1'b1, 32'hFFFF_FFFF);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL wr_done: got %b want 0001", done); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rdata); end
    @(negedge clock);
    #1;
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL wr_done_pulse: got %b want 0000", done); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_address[2*AW +: AW] = 32'h0000_0040;
    req_rd_we[2]            = 1'b1;
    req                     = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt: got %b want 0100", gnt); end
    @(negedge clock);
    req = 4'b0000;
    #1;
    checks++; if ({spi_enable, spi_rd_we, spi_address} !== {2'b11, 32'h40}) begin errors++; $display("FAIL rd_issue: got en=%b rdwe=%b addr=%h", spi_enable, spi_rd_we, spi_address); end
    spi_serve(2, 1'b1, 32'hDEAD_BEEF);
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL rd_done: got %b want 0100", done); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", rdata); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]); end
      @(negedge clock);
      spi_serve(1, 1'b0, '0);
      checks++; if (done !== exp_g[k]) begin errors++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, exp_g[k]); end
      @(negedge clock);
      #1;
    end
    req = 4'b0000;
    @(negedge clock);
    spi_serve(1, 1'b0, '0);
  endtask

  task automatic test_busy_block();
    do_reset();
    spi_busy = 1'b1;
    req      = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL busy_nogrant[%0d]: got %b want 0000", k, gnt); end
      @(negedge clock);
    end
    spi_busy = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL busy_grant: got %b want 0010", gnt); end
    @(negedge clock);
    req = 4'b0000;
    spi_serve(1, 1'b0, '0);
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL busy_done: got %b want 0010", done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_address[1*AW +: AW] = 32'h0000_0077;
    req_data[1*DW +: DW]    = 32'h0000_5555;
    req = 4'b0010;
    @(negedge clock);
    spi_busy = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    req     = 4'b1001;
    #1;
    checks++; if ({gnt, done, err, spi_enable, spi_rd_we} !== 11'b0) begin errors++; $display("FAIL rst_mid_ctrl: got gnt=%b done=%b err=%b en=%b", gnt, done, err, spi_enable); end
    checks++; if ({rdata, spi_address, spi_data} !== 96'h0) begin errors++; $display("FAIL rst_mid_data: got %h %h %h want 0", rdata, spi_address, spi_data); end
    spi_busy = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if ({gnt, done} !== {4'b0001, 4'b0000}) begin errors++; $display("FAIL rst_mid_next: got gnt=%b done=%b want 0001 0000", gnt, done); end
    @(negedge clock);
    req = 4'b0000;
    spi_serve(1, 1'b0, '0);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rst_mid_done: got %b want 0001", done); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    @(negedge clock);
    req      = 4'b0000;
    spi_busy = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      @(negedge clock);
      #1;
      if (done !== 4'b0000 || err !== 1'b0) begin
        checks++; errors++;
        $display("FAIL to_early[%0d]: got done=%b err=%b want 0", k, done, err);
      end
    end
    @(negedge clock);
    #1;
    checks++; if ({done, err} !== {4'b0001, 1'b1}) begin errors++; $display("FAIL to_fire: got done=%b err=%b want 0001 1", done, err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", rdata); end
    @(negedge clock);
    #1;
    checks++; if ({done, err} !== 5'b0) begin errors++; $display("FAIL to_pulse: got done=%b err=%b want 0", done, err); end
    spi_busy = 1'b0;
    @(negedge clock);
`else
    for (int k = 1; k < TO + 50; k++) begin
      @(negedge clock);
      #1;
      if (done !== 4'b0000 || err !== 1'b0) begin
        checks++; errors++;
        $display("FAIL nto_wait[%0d]: got done=%b err=%b want 0", k, done, err);
      end
    end
    checks++; if (spi_address !== 32'h0) begin errors++; $display("FAIL nto_hold: got %h want 0", spi_address); end
    spi_busy = 1'b0;
    @(negedge clock);
    #1;
    checks++; if ({done, err} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL nto_done: got done=%b err=%b want 0001 0", done, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_fairness();
    test_busy_block();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SPI data field width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, SPI address field width.
REQ-004 SHALL have parameter TIMEOUT, default 65535, watchdog limit in clock cycles (16-bit).
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports: clock in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: req in NUM_REQ, request per requester; req_rd_we in NUM_REQ, 1=read, 0=write.
REQ-007 SHALL have ports: req_address in NUM_REQ*ADDRESS_WIDTH, packed addresses; req_data in NUM_REQ*DATA_WIDTH, packed write data.
REQ-008 SHALL have ports: gnt out NUM_REQ, one-hot accept pulse; done out NUM_REQ, one-hot completion pulse; rdata out DATA_WIDTH, read result; err out 1, timeout flag.
REQ-009 SHALL have master-side ports: spi_enable out 1; spi_rd_we out 1; spi_address out ADDRESS_WIDTH; spi_data out DATA_WIDTH; spi_busy in 1; spi_data_read in DATA_WIDTH; spi_data_read_valid in 1.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_DONE, RESP.
REQ-011 IDLE: when any req bit is high and spi_busy=0, SHALL select one requester round-robin, pulse gnt[idx] for 1 cycle, latch rd_we/address/data, and enter ISSUE next cycle.
REQ-012 Round-robin: search SHALL start at (last_idx+1) mod NUM_REQ; last_idx updates on each grant.
REQ-013 ISSUE: SHALL hold spi_enable=1 with latched payload on spi_* until spi_busy=1, then drop spi_enable the same cycle and enter WAIT_DONE.
REQ-014 WAIT_DONE: SHALL capture spi_data_read into rdata on any cycle with spi_data_read_valid=1; on spi_busy=0 SHALL enter RESP.
REQ-015 RESP: SHALL pulse done[idx] for exactly 1 cycle with rdata valid (writes: rdata=0), then return to IDLE.
REQ-016 spi_address/spi_data/spi_rd_we SHALL remain stable from ISSUE through WAIT_DONE.
REQ-017 Minimum grant-to-done latency SHALL be 3 cycles plus SPI transaction time; back-to-back transactions SHALL have 1 IDLE cycle between them.
REQ-018 req deassertion after gnt SHALL NOT affect the transaction; req changes in non-IDLE states SHALL be ignored.
REQ-019 A requester holding req after done SHALL be re-arbitrated behind all other pending requesters.
REQ-020 If spi_busy=1 in IDLE, no grant SHALL occur until spi_busy=0.
REQ-021 gnt and done SHALL never have more than one bit set.

Reset
REQ-022 On reset_n=0: state=IDLE, gnt=0, done=0, rdata=0, err=0, spi_enable=0, spi_rd_we=0, spi_address=0, spi_data=0, last_idx=NUM_REQ-1 (requester 0 wins first).
REQ-023 Reset mid-transaction SHALL abort immediately with no done pulse after release.

Configuration
REQ-024 With SPI_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering ISSUE and increment each cycle in ISSUE/WAIT_DONE; at TIMEOUT it SHALL force spi_enable=0, enter RESP, and pulse err together with done[idx], rdata=0.
REQ-025 Without SPI_ARB_TIMEOUT_EN: no counter SHALL exist, err SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-026 Package spi_arb_pkg SHALL hold the state encoding and default width/TIMEOUT constants.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_idx in; one-hot grant and index out, combinational).

Verification
REQ-028 Single write: req=0001, addr=0xA5, data=0x1234 -> gnt=0001, spi_enable until spi_busy, done=0001 after spi_busy falls, rdata=0.
REQ-029 Single read: req=0100, rd_we=1, model returns 0xDEADBEEF -> done=0100, rdata=0xDEADBEEF.
REQ-030 Fairness: req=1111 held continuously -> grants in order 0001,0010,0100,1000,0001.
REQ-031 Busy blocking: spi_busy=1 in IDLE with req=0010 -> no gnt until spi_busy=0, then gnt=0010.
REQ-032 Reset mid-WAIT_DONE -> all outputs 0 within reset assertion; next grant goes to requester 0.
REQ-033 With SPI_ARB_TIMEOUT_EN, TIMEOUT=100, spi_busy stuck 1 -> err and done pulse at cycle 100 after ISSUE entry.
